// File: rtl/audio_tone_pkg.sv
// rtl/audio_tone_pkg.sv - register map, fifospace fields and FSM states for the tone writer
package audio_tone_pkg;

  localparam logic [1:0] ADDR_CTRL      = 2'd0;
  localparam logic [1:0] ADDR_FIFOSPACE = 2'd1;
  localparam logic [1:0] ADDR_LEFT      = 2'd2;
  localparam logic [1:0] ADDR_RIGHT     = 2'd3;

  localparam int FIELD_W  = 8;
  localparam int WSRC_LSB = 24;
  localparam int WSLC_LSB = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POLL,
    ST_WAIT,
    ST_CHECK,
    ST_WR_L,
    ST_WR_R,
    ST_ADVANCE
  } state_t;

endpackage

// File: rtl/tone_phase_acc.sv
// rtl/tone_phase_acc.sv - phase accumulator and waveform mapping
// AUDIO_TONE_SAW_EN selects a scaled sawtooth; default is a square wave with no multiplier.
module tone_phase_acc #(
  parameter int PHASE_W  = 24,
  parameter int SAMPLE_W = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_advance,
  input  logic [PHASE_W-1:0]  i_phase_inc,
  input  logic [SAMPLE_W-2:0] i_amplitude,
  output logic [SAMPLE_W-1:0] o_sample
);

  logic [PHASE_W-1:0]  r_phase;
  logic [SAMPLE_W-1:0] w_pos;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= '0;
    end else if (i_advance) begin
      r_phase <= r_phase + i_phase_inc;
    end
  end

  assign w_pos = {1'b0, i_amplitude};

`ifdef AUDIO_TONE_SAW_EN
  localparam int PROD_W = 2 * SAMPLE_W;

  logic signed [SAMPLE_W-1:0] w_top;
  logic signed [PROD_W-1:0]   w_prod;
  logic signed [PROD_W-1:0]   w_scaled;
  logic signed [PROD_W-1:0]   w_pos_ext;
  logic signed [PROD_W-1:0]   w_neg_ext;
  logic signed [PROD_W-1:0]   w_clip;

  assign w_top     = $signed(r_phase[PHASE_W-1 -: SAMPLE_W]);
  assign w_prod    = w_top * $signed(w_pos);
  assign w_scaled  = w_prod >>> (SAMPLE_W - 1);
  assign w_pos_ext = $signed({{SAMPLE_W{1'b0}}, w_pos});
  assign w_neg_ext = -w_pos_ext;

  always_comb begin
    w_clip = w_scaled;
    if (w_scaled > w_pos_ext) begin
      w_clip = w_pos_ext;
    end else if (w_scaled < w_neg_ext) begin
      w_clip = w_neg_ext;
    end
  end

  assign o_sample = w_clip[SAMPLE_W-1:0];
`else
  // First half of each cycle is the positive half of the square.
  assign o_sample = r_phase[PHASE_W-1] ? -w_pos : w_pos;
`endif

endmodule

// File: rtl/audio_tone_writer.sv
// rtl/audio_tone_writer.sv - Avalon-MM master streaming a synthesised tone into the audio core
// Optional sawtooth waveform via AUDIO_TONE_SAW_EN (see tone_phase_acc).
module audio_tone_writer
  import audio_tone_pkg::*;
#(
  parameter int PHASE_W  = 24,
  parameter int SAMPLE_W = 24,
  parameter int CNT_W    = 16
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic                enable,
  input  logic [PHASE_W-1:0]  phase_inc,
  input  logic [SAMPLE_W-2:0] amplitude,
  output logic [1:0]          avm_address,
  output logic                avm_chipselect,
  output logic                avm_read,
  output logic                avm_write,
  output logic [31:0]         avm_writedata,
  input  logic [31:0]         avm_readdata,
  output logic                busy,
  output logic [CNT_W-1:0]    samples_written
);

  localparam int EXT_W = 32 - SAMPLE_W;

  state_t               r_state;
  state_t               w_next;
  logic [FIELD_W-1:0]   r_wslc;
  logic [FIELD_W-1:0]   r_wsrc;
  logic [CNT_W-1:0]     r_samples_written;
  logic [SAMPLE_W-1:0]  w_sample;
  logic [31:0]          w_sample_ext;
  logic                 w_advance;
  logic                 w_unused;

  assign w_advance    = (r_state == ST_ADVANCE);
  assign w_sample_ext = {{EXT_W{w_sample[SAMPLE_W-1]}}, w_sample};
  assign w_unused     = ^avm_readdata[WSLC_LSB-1:0];

  tone_phase_acc #(
    .PHASE_W  (PHASE_W),
    .SAMPLE_W (SAMPLE_W)
  ) u_phase_acc (
    .clk         (clk_clk),
    .rst_n       (reset_reset_n),
    .i_advance   (w_advance),
    .i_phase_inc (phase_inc),
    .i_amplitude (amplitude),
    .o_sample    (w_sample)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state           <= ST_IDLE;
      r_wslc            <= '0;
      r_wsrc            <= '0;
      r_samples_written <= '0;
    end else begin
      r_state <= w_next;
      // readdata is valid in the cycle after the read strobe, i.e. while in WAIT.
      if (r_state == ST_WAIT) begin
        r_wslc <= avm_readdata[WSLC_LSB +: FIELD_W];
        r_wsrc <= avm_readdata[WSRC_LSB +: FIELD_W];
      end
      if (w_advance) begin
        r_samples_written <= r_samples_written + 1'b1;
      end
    end
  end

  always_comb begin
    w_next         = r_state;
    avm_address    = ADDR_CTRL;
    avm_chipselect = 1'b0;
    avm_read       = 1'b0;
    avm_write      = 1'b0;
    avm_writedata  = '0;
    case (r_state)
      ST_IDLE: begin
        if (enable) w_next = ST_POLL;
      end
      ST_POLL: begin
        avm_read       = 1'b1;
        avm_chipselect = 1'b1;
        avm_address    = ADDR_FIFOSPACE;
        w_next         = ST_WAIT;
      end
      ST_WAIT: begin
        w_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (!enable) begin
          w_next = ST_IDLE;
        end else if ((r_wslc != '0) && (r_wsrc != '0)) begin
          w_next = ST_WR_L;
        end else begin
          w_next = ST_POLL;
        end
      end
      ST_WR_L: begin
        avm_write      = 1'b1;
        avm_chipselect = 1'b1;
        avm_address    = ADDR_LEFT;
        avm_writedata  = w_sample_ext;
        w_next         = ST_WR_R;
      end
      // Right always follows left regardless of enable so channels stay aligned.
      ST_WR_R: begin
        avm_write      = 1'b1;
        avm_chipselect = 1'b1;
        avm_address    = ADDR_RIGHT;
        avm_writedata  = w_sample_ext;
        w_next         = ST_ADVANCE;
      end
      ST_ADVANCE: begin
        w_next = enable ? ST_POLL : ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign busy            = (r_state != ST_IDLE);
  assign samples_written = r_samples_written;

endmodule

// File: tb/tb_audio_tone_writer.sv
// tb/tb_audio_tone_writer.sv - directed self-checking bench for audio_tone_writer
module tb_audio_tone_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rst_w_n;
  logic        enable;
  logic        enable_w;
  logic [23:0] phase_inc;
  logic [22:0] amplitude;
  logic [31:0] readdata;

  logic [1:0]  address;
  logic        cs;
  logic        rd;
  logic        wr;
  logic [31:0] wdata;
  logic        busy;
  logic [15:0] cnt;

  logic [1:0]  address_w;
  logic        cs_w;
  logic        rd_w;
  logic        wr_w;
  logic [31:0] wdata_w;
  logic        busy_w;
  logic [3:0]  cnt_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  audio_tone_writer #(.PHASE_W(24), .SAMPLE_W(24), .CNT_W(16)) dut (
    .clk_clk         (clk),
    .reset_reset_n   (rst_n),
    .enable          (enable),
    .phase_inc       (phase_inc),
    .amplitude       (amplitude),
    .avm_address     (address),
    .avm_chipselect  (cs),
    .avm_read        (rd),
    .avm_write       (wr),
    .avm_writedata   (wdata),
    .avm_readdata    (readdata),
    .busy            (busy),
    .samples_written (cnt)
  );

  // Narrow-counter instance so wrap-around is reachable in a short run.
  audio_tone_writer #(.PHASE_W(24), .SAMPLE_W(24), .CNT_W(4)) dut_w (
    .clk_clk         (clk),
    .reset_reset_n   (rst_w_n),
    .enable          (enable_w),
    .phase_inc       (phase_inc),
    .amplitude       (amplitude),
    .avm_address     (address_w),
    .avm_chipselect  (cs_w),
    .avm_read        (rd_w),
    .avm_write       (wr_w),
    .avm_writedata   (wdata_w),
    .avm_readdata    (readdata),
    .busy            (busy_w),
    .samples_written (cnt_w)
  );

  task automatic do_reset();
    enable = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
  endtask

  task automatic wait_write(input logic [1:0] addr, input int max_cycles, output bit found);
    found = 1'b0;
    for (int i = 0; i < max_cycles && !found; i++) begin
      @(negedge clk);
      if (wr && address == addr) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    enable    = 1'b1;
    readdata  = 32'h0101_0000;
    phase_inc = 24'h40_0000;
    amplitude = 23'h100;
    repeat (3) @(negedge clk);
    checks++;
    if ({rd, wr, cs, address, wdata, cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rd=%b wr=%b cs=%b addr=%0d wdata=%h cnt=%h expected all 0",
               rd, wr, cs, address, wdata, cnt);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b expected 0", busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (rd !== 1'b1 || cs !== 1'b1 || address !== 2'd1 || wr !== 1'b0) begin
      errors++;
      $display("FAIL first_poll got rd=%b cs=%b addr=%0d wr=%b expected rd=1 cs=1 addr=1 wr=0",
               rd, cs, address, wr);
    end
  endtask

  task automatic test_square();
    logic [1:0]  a   [8];
    logic [31:0] d   [8];
    int          cyc [8];
    int          n;
    bit          overlap;
    logic [1:0]  exp_a;
    logic [31:0] exp_d;
    n       = 0;
    overlap = 1'b0;
    do_reset();
    phase_inc = 24'h40_0000;
    amplitude = 23'h100;
    readdata  = 32'h0101_0000;
    enable    = 1'b1;
    for (int c = 1; c <= 80 && n < 8; c++) begin
      @(negedge clk);
      if (rd && wr) overlap = 1'b1;
      if (wr) begin
        a[n]   = address;
        d[n]   = wdata;
        cyc[n] = c;
        n++;
      end
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL square_write_count got %0d expected 8", n);
    end
    for (int i = 0; i < n; i++) begin
      exp_a = (i % 2 == 0) ? 2'd2 : 2'd3;
      exp_d = (i < 4) ? 32'h0000_0100 : 32'hFFFF_FF00;
      checks++;
      if (a[i] !== exp_a || d[i] !== exp_d) begin
        errors++;
        $display("FAIL square_write_%0d got addr=%0d data=%h expected addr=%0d data=%h",
                 i, a[i], d[i], exp_a, exp_d);
      end
    end
    if (n == 8) begin
      checks++;
      if (cyc[0] != 4 || cyc[2] - cyc[0] != 6 || cyc[6] - cyc[4] != 6) begin
        errors++;
        $display("FAIL square_timing got first=%0d gap1=%0d gap3=%0d expected 4 6 6",
                 cyc[0], cyc[2] - cyc[0], cyc[6] - cyc[4]);
      end
    end
    checks++;
    if (overlap) begin
      errors++;
      $display("FAIL strobe_overlap got read and write both 1 expected never");
    end
    repeat (2) @(negedge clk);
    checks++;
    if (cnt !== 16'd4) begin
      errors++;
      $display("FAIL square_count got %0d expected 4", cnt);
    end
  endtask

  task automatic test_no_room();
    int nrd;
    int last;
    bit bad_gap;
    bit wrote;
    bit found;
    nrd     = 0;
    last    = -1;
    bad_gap = 1'b0;
    wrote   = 1'b0;
    do_reset();
    phase_inc = 24'h40_0000;
    amplitude = 23'h100;
    readdata  = 32'h0005_0000;
    enable    = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      if (wr) wrote = 1'b1;
      if (rd) begin
        if (last >= 0 && c - last != 3) bad_gap = 1'b1;
        if (last < 0 && c != 1) bad_gap = 1'b1;
        last = c;
        nrd++;
      end
    end
    checks++;
    if (wrote) begin
      errors++;
      $display("FAIL no_room_write got a write expected none");
    end
    checks++;
    if (nrd != 7 || bad_gap) begin
      errors++;
      $display("FAIL no_room_polls got reads=%0d bad_gap=%0b expected 7 reads every 3 cycles", nrd, bad_gap);
    end
    readdata = 32'h0105_0000;
    wait_write(2'd2, 10, found);
    checks++;
    if (!found || wdata !== 32'h0000_0100) begin
      errors++;
      $display("FAIL room_restored got found=%0b data=%h expected left write 00000100", found, wdata);
    end
  endtask

  task automatic test_enable_drop();
    bit found;
    bit polled;
    bit wrote;
    do_reset();
    phase_inc = 24'h40_0000;
    amplitude = 23'h100;
    readdata  = 32'h0101_0000;
    enable    = 1'b1;
    wait_write(2'd2, 10, found);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL drop_wr_l_timeout got no left write expected one");
    end
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (wr !== 1'b1 || address !== 2'd3) begin
      errors++;
      $display("FAIL drop_wr_r got wr=%b addr=%0d expected wr=1 addr=3", wr, address);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || rd !== 1'b0 || wr !== 1'b0 || cs !== 1'b0) begin
      errors++;
      $display("FAIL drop_advance got busy=%b rd=%b wr=%b cs=%b expected 1 0 0 0", busy, rd, wr, cs);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cnt !== 16'd1) begin
      errors++;
      $display("FAIL drop_idle got busy=%b cnt=%0d expected busy=0 cnt=1", busy, cnt);
    end
    polled = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (rd || busy) polled = 1'b1;
    end
    checks++;
    if (polled) begin
      errors++;
      $display("FAIL drop_stays_idle got activity expected idle");
    end
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    checks++;
    if (rd !== 1'b1) begin
      errors++;
      $display("FAIL drop_poll_start got rd=%b expected 1", rd);
    end
    wrote = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (wr) wrote = 1'b1;
    end
    checks++;
    if (wrote || busy !== 1'b0 || cnt !== 16'd1) begin
      errors++;
      $display("FAIL drop_in_poll got wrote=%0b busy=%b cnt=%0d expected no write busy=0 cnt=1", wrote, busy, cnt);
    end
  endtask

  task automatic test_counter_wrap();
    bit reached;
    int k;
    reached   = 1'b0;
    k         = 0;
    phase_inc = 24'h40_0000;
    amplitude = 23'h100;
    readdata  = 32'h0101_0000;
    enable_w  = 1'b1;
    @(negedge clk);
    rst_w_n = 1'b1;
    for (int i = 0; i < 300 && !reached; i++) begin
      @(negedge clk);
      if (cnt_w == 4'hF) reached = 1'b1;
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL wrap_reach_max got cnt=%h expected to reach F", cnt_w);
    end
    while (k < 12 && cnt_w == 4'hF) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (cnt_w !== 4'h0 || k != 6) begin
      errors++;
      $display("FAIL wrap_to_zero got cnt=%h after %0d cycles expected 0 after 6", cnt_w, k);
    end
    rst_w_n = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    bit found;
    do_reset();
    phase_inc = 24'h80_0000;
    amplitude = 23'h100;
    readdata  = 32'h0101_0000;
    enable    = 1'b1;
    wait_write(2'd2, 10, found);
    wait_write(2'd2, 10, found);
    checks++;
    if (!found || wdata !== 32'hFFFF_FF00) begin
      errors++;
      $display("FAIL midrst_second_pair got found=%0b data=%h expected FFFFFF00", found, wdata);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (wr !== 1'b0 || cs !== 1'b0 || busy !== 1'b0 || cnt !== 16'd0) begin
      errors++;
      $display("FAIL midrst_abort got wr=%b cs=%b busy=%b cnt=%0d expected 0 0 0 0", wr, cs, busy, cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_write(2'd2, 10, found);
    checks++;
    if (!found || wdata !== 32'h0000_0100) begin
      errors++;
      $display("FAIL midrst_phase_zero got found=%0b data=%h expected 00000100", found, wdata);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    rst_w_n   = 1'b0;
    enable    = 1'b0;
    enable_w  = 1'b0;
    phase_inc = '0;
    amplitude = '0;
    readdata  = '0;
    @(negedge clk);
    test_reset();
    test_square();
    test_no_room();
    test_enable_drop();
    test_counter_wrap();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
